// File: rtl/dkong3_snd_mixer.sv
// rtl/dkong3_snd_mixer.sv - time-multiplexed N-channel signed audio mixer with gain, mute and saturation
// Optional DC-blocking output filter enabled by defining DKONG3_MIX_DCBLOCK_EN.
module dkong3_snd_mixer #(
    parameter int NUM_CH = 2,
    parameter int SW     = 16,
    parameter int GW     = 4,
    parameter int SHIFT  = 4
) (
    input  logic                 I_CLK_24M,
    input  logic                 I_RESETn,
    input  logic                 I_SAMPLE_STB,
    input  logic [NUM_CH*SW-1:0] I_SAMPLES,
    input  logic [NUM_CH*GW-1:0] I_GAIN,
    input  logic [NUM_CH-1:0]    I_MUTE,
    output logic [SW-1:0]        O_SAMPLE,
    output logic                 O_VALID,
    output logic                 O_CLIP,
    output logic                 O_BUSY,
    output logic                 O_OVERRUN
);

    localparam int AW = SW + GW + $clog2(NUM_CH) + 1;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);
    localparam logic signed [AW-1:0] SMAX = {{(AW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-SW+1){1'b1}}, {(SW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, FILT} state_t;

    state_t               state;
    logic [NUM_CH*SW-1:0] samp_snap;
    logic [NUM_CH*GW-1:0] gain_snap;
    logic [NUM_CH-1:0]    mute_snap;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        ch;

    logic [SW-1:0]        cur_s;
    logic [GW-1:0]        cur_g;
    logic signed [AW-1:0] s_ext, g_ext, prod, r;
    logic [SW:0]          r_sat;

    // Returns {clip, value} with value clamped to the signed SW-bit range.
    function automatic logic [SW:0] sat(input logic signed [AW-1:0] v);
        if (v > SMAX)
            sat = {1'b1, SMAX[SW-1:0]};
        else if (v < SMIN)
            sat = {1'b1, SMIN[SW-1:0]};
        else
            sat = {1'b0, v[SW-1:0]};
    endfunction

    always_comb begin
        cur_s = samp_snap[int'(ch)*SW +: SW];
        cur_g = gain_snap[int'(ch)*GW +: GW];
        s_ext = {{(AW-SW){cur_s[SW-1]}}, cur_s};
        g_ext = {{(AW-GW){1'b0}}, cur_g};
        prod  = mute_snap[ch] ? '0 : s_ext * g_ext;
        r     = acc >>> SHIFT;
        r_sat = sat(r);
    end

`ifdef DKONG3_MIX_DCBLOCK_EN
    logic [SW-1:0]        x_reg, x_prev, y_prev;
    logic                 clip_r;
    logic signed [AW-1:0] x_ext, xp_ext, yp_ext, y_full;
    logic [SW:0]          y_sat;

    always_comb begin
        x_ext  = {{(AW-SW){x_reg[SW-1]}}, x_reg};
        xp_ext = {{(AW-SW){x_prev[SW-1]}}, x_prev};
        yp_ext = {{(AW-SW){y_prev[SW-1]}}, y_prev};
        y_full = x_ext - xp_ext + yp_ext - (yp_ext >>> 8);
        y_sat  = sat(y_full);
    end
`endif

    assign O_BUSY = (state != IDLE);

    always_ff @(posedge I_CLK_24M) begin
        if (!I_RESETn) begin
            state     <= IDLE;
            samp_snap <= '0;
            gain_snap <= '0;
            mute_snap <= '0;
            acc       <= '0;
            ch        <= '0;
            O_SAMPLE  <= '0;
            O_VALID   <= 1'b0;
            O_CLIP    <= 1'b0;
            O_OVERRUN <= 1'b0;
`ifdef DKONG3_MIX_DCBLOCK_EN
            x_reg     <= '0;
            x_prev    <= '0;
            y_prev    <= '0;
            clip_r    <= 1'b0;
`endif
        end else begin
            O_VALID <= 1'b0;
            O_CLIP  <= 1'b0;
            if (I_SAMPLE_STB && state != IDLE)
                O_OVERRUN <= 1'b1;
            case (state)
                IDLE: begin
                    if (I_SAMPLE_STB) begin
                        samp_snap <= I_SAMPLES;
                        gain_snap <= I_GAIN;
                        mute_snap <= I_MUTE;
                        acc       <= '0;
                        ch        <= '0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + prod;
                    if (ch == LAST_CH)
                        state <= SCALE;
                    else
                        ch <= ch + 1'b1;
                end
                SCALE: begin
`ifdef DKONG3_MIX_DCBLOCK_EN
                    x_reg  <= r_sat[SW-1:0];
                    clip_r <= r_sat[SW];
                    state  <= FILT;
`else
                    O_SAMPLE <= r_sat[SW-1:0];
                    O_CLIP   <= r_sat[SW];
                    O_VALID  <= 1'b1;
                    state    <= IDLE;
`endif
                end
`ifdef DKONG3_MIX_DCBLOCK_EN
                FILT: begin
                    O_SAMPLE <= y_sat[SW-1:0];
                    O_CLIP   <= clip_r | y_sat[SW];
                    O_VALID  <= 1'b1;
                    x_prev   <= x_reg;
                    y_prev   <= y_sat[SW-1:0];
                    state    <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
